demux_conductual: RTL

- Receive-side counterpart of the 2:1 alternating-lane mux; clocked, behavioural description.
- Takes a single interleaved WIDTH-bit stream and reassembles it into two parallel lanes, data_0 and data_1.
- Stream order is fixed: the first word of each pair belongs to lane 1 and the second to lane 0.
- Presents each completed pair on registered outputs with a one-cycle valid_out strobe. Sits directly after the interleaved link, ahead of per-lane consumers.

---
 rtl/demux_conductual.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/demux_conductual.sv
// -----------------------------------------------------------------------------
// demux_conductual
//   Receive side of the 2:1 alternating-lane link. Splits one interleaved
//   WIDTH-bit word stream back into two parallel lanes. In each pair, the first
//   word belongs to lane 1 and the second word belongs to lane 0. Each
//   completed pair appears on registered outputs together with a one-cycle
//   valid_out strobe.
//
// Optional build macro: DEMUX_PAIR_CNT_EN
//   When this macro is defined, the pair_cnt port and its wrapping
//   completed-pair counter are present. When it is undefined, both are absent.
//
// Ports
//   clk        in   rising-edge clock
//   reset_L    in   asynchronous active-low reset
//   data_in    in   interleaved input word (WIDTH)
//   valid_in   in   data_in is accepted at this edge (never back-pressured)
//   sync       in   realign: the word accepted at this edge starts a pair
//   data_0     out  lane-0 word of the last completed pair (registered)
//   data_1     out  lane-1 word of the last completed pair (registered)
//   valid_out  out  one-cycle strobe: a new pair is on data_0/data_1
//   pending    out  a lane-1 word is held (FSM state: EXPECT_L0)
//   pair_cnt   out  completed-pair count, wraps (DEMUX_PAIR_CNT_EN only)
//
// Handshake: a word transfers at every rising edge where valid_in is high.
// There is no ready signal; the block always accepts. valid_out is a plain
// strobe with no ready, and consumers must take data_0/data_1 in that cycle
// or sample them later, since the outputs hold until the next pair completes.
// -----------------------------------------------------------------------------
module demux_conductual #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             sync,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic             valid_out,
`ifdef DEMUX_PAIR_CNT_EN
  output logic [CNT_W-1:0] pair_cnt,
`endif
  output logic             pending
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("demux_conductual: CNT_W must be at least 1");
  end

  // The phase state doubles as the pending output, so pending is the
  // observable view of the FSM.
  typedef enum logic {
    EXPECT_L1 = 1'b0,
    EXPECT_L0 = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] data_0_q, data_0_d;
  logic [WIDTH-1:0] data_1_q, data_1_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= EXPECT_L1;
      hold_q   <= '0;
      data_0_q <= '0;
      data_1_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      data_0_q <= data_0_d;
      data_1_q <= data_1_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    data_0_d = data_0_q;
    data_1_d = data_1_q;
    valid_d  = 1'b0;

    if (sync) begin
      // Realign overrides the phase. Any half-pair already held is dropped
      // without producing a strobe.
      if (valid_in) begin
        hold_d  = data_in;
        state_d = EXPECT_L0;
      end else begin
        hold_d  = '0;
        state_d = EXPECT_L1;
      end
    end else begin
      unique case (state_q)
        EXPECT_L1: begin
          if (valid_in) begin
            hold_d  = data_in;
            state_d = EXPECT_L0;
          end
        end
        EXPECT_L0: begin
          // The held word survives arbitrary gaps until its partner arrives.
          if (valid_in) begin
            data_1_d = hold_q;
            data_0_d = data_in;
            valid_d  = 1'b1;
            state_d  = EXPECT_L1;
          end
        end
        default: state_d = EXPECT_L1;
      endcase
    end
  end

`ifdef DEMUX_PAIR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Advances at the same edge that raises valid_out and wraps naturally.
  // sync has no effect on this counter.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_d) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign pair_cnt = cnt_q;
`endif

  assign data_0    = data_0_q;
  assign data_1    = data_1_q;
  assign valid_out = valid_q;
  assign pending   = (state_q == EXPECT_L0);

endmodule
